// File: rtl/apu_pkg.sv
// Purpose: shared types and sizes for the APU sound-effect scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apu_pkg;

    localparam int TONE_W      = 4;                    // one tone-override nibble
    localparam int NUM_TONE_CH = 4;                    // t0..t3
    localparam int SFX_W       = TONE_W * NUM_TONE_CH; // packed {t0,t1,t2,t3}

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } sfx_state_e;

endpackage

// File: rtl/prio_pick.sv
// Purpose: fixed-priority encoder, lowest set index wins.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (request vector), vld (any bit set), idx (lowest set index, 0 when none).
module prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     vec,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        vld = |vec;
        idx = '0;
        // Walk from the top down so the lowest set index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Purpose: fixed-priority, preemptive scheduler of one-shot sound effects onto the APU tone overrides.
// Latency: req rising edge at cycle N -> ack and overrides at N+2; natural expiry -> done one cycle after the final note tick.
// Backpressure: none; a request rising while already pending is absorbed, preempted effects are dropped.
// Ports:
//   clk, reset         APU slow clock, asynchronous active-high reset
//   note_clk           note clock level; rising edges are duration ticks
//   enable             0 freezes the duration counter (grants still happen)
//   flush              synchronous clear of pending requests and the active effect
//   req                request lines, rising edge latches a request
//   sfx_word, sfx_dur  per-requester effect word {t0,t1,t2,t3} and tick count, captured at grant
//   t0_os..t3_os       tone overrides to the APU, 0 = no override
//   busy, active_id    effect active / which requester owns it
//   ack, done          one-cycle grant pulse per requester / natural completion pulse
module sfx_scheduler
    import apu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DUR_W   = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       note_clk,
    input  logic                       enable,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [SFX_W*NUM_REQ-1:0]   sfx_word,
    input  logic [DUR_W*NUM_REQ-1:0]   sfx_dur,
    output logic [TONE_W-1:0]          t0_os,
    output logic [TONE_W-1:0]          t1_os,
    output logic [TONE_W-1:0]          t2_os,
    output logic [TONE_W-1:0]          t3_os,
    output logic                       busy,
    output logic [ID_W-1:0]            active_id,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       done
);

    sfx_state_e          state, state_nxt;
    logic                armed;
    logic [NUM_REQ-1:0]  req_q, req_rise;
    logic                note_q, tick;
    logic [NUM_REQ-1:0]  pending, pending_nxt;
    logic [DUR_W-1:0]    cnt, cnt_nxt, dur_sel;
    logic [SFX_W-1:0]    word_q, word_nxt, word_sel;
    logic                pick_vld;
    logic [ID_W-1:0]     pick_idx;
    logic                grant, expire;
    logic                busy_nxt, done_nxt;
    logic [NUM_REQ-1:0]  ack_nxt;
    logic [ID_W-1:0]     active_nxt;

    // Edge registers clear to 0 on reset, so a request line still held high
    // would look like a fresh rise on the first cycle out of reset. 'armed'
    // masks edges for that one cycle while req_q/note_q pick up the levels.
    assign req_rise = armed ? (req & ~req_q) : '0;
    assign tick     = armed & note_clk & ~note_q;

    // One encoder serves both the idle grant and the preemption compare:
    // the lowest pending index is the only candidate that could ever win.
    prio_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .vec (pending),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_comb begin
        word_sel = '0;
        dur_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                word_sel = sfx_word[i*SFX_W +: SFX_W];
                dur_sel  = sfx_dur[i*DUR_W +: DUR_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. A grant (including preemption) outranks a same-cycle expiry.
    always_comb begin
        grant     = 1'b0;
        expire    = 1'b0;
        state_nxt = state;
        if (!flush) begin
            if (pick_vld && (state == IDLE || pick_idx < active_id)) begin
                grant = 1'b1;
            end else if (state == PLAY && tick && enable && cnt == DUR_W'(1)) begin
                expire = 1'b1;
            end
        end
        if (flush) begin
            state_nxt = IDLE;
        end else if (grant) begin
            state_nxt = PLAY;
        end else if (expire) begin
            state_nxt = IDLE;
        end
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        ack_nxt     = '0;
        done_nxt    = expire;
        busy_nxt    = (state_nxt == PLAY);
        active_nxt  = active_id;
        word_nxt    = word_q;
        cnt_nxt     = cnt;
        pending_nxt = pending | req_rise;
        if (flush) begin
            // Rises coinciding with flush are dropped along with everything else.
            pending_nxt = '0;
            word_nxt    = '0;
        end else if (grant) begin
            ack_nxt     = NUM_REQ'(1) << pick_idx;
            pending_nxt = (pending & ~ack_nxt) | req_rise;
            active_nxt  = pick_idx;
            word_nxt    = word_sel;
            cnt_nxt     = (dur_sel == '0) ? DUR_W'(1) : dur_sel;
        end else if (state == PLAY && tick && enable) begin
            cnt_nxt = cnt - DUR_W'(1);
            if (expire) begin
                word_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed     <= 1'b0;
            req_q     <= '0;
            note_q    <= 1'b0;
            pending   <= '0;
            cnt       <= '0;
            word_q    <= '0;
            busy      <= 1'b0;
            active_id <= '0;
            ack       <= '0;
            done      <= 1'b0;
        end else begin
            armed     <= 1'b1;
            req_q     <= req;
            note_q    <= note_clk;
            pending   <= pending_nxt;
            cnt       <= cnt_nxt;
            word_q    <= word_nxt;
            busy      <= busy_nxt;
            active_id <= active_nxt;
            ack       <= ack_nxt;
            done      <= done_nxt;
        end
    end

    assign t0_os = word_q[SFX_W-1            -: TONE_W];
    assign t1_os = word_q[SFX_W-1-TONE_W     -: TONE_W];
    assign t2_os = word_q[SFX_W-1-2*TONE_W   -: TONE_W];
    assign t3_os = word_q[SFX_W-1-3*TONE_W   -: TONE_W];

endmodule

// File: tb/tb_sfx_scheduler.sv
// Purpose: scoreboard bench for sfx_scheduler with directed scenarios.
// Latency: expected ack/done events carry the cycle they must appear on.
// Backpressure: n/a.
module tb_sfx_scheduler;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        note_clk = 1'b0;
    logic        enable   = 1'b1;
    logic        flush    = 1'b0;
    logic [3:0]  req      = '0;
    logic [63:0] sfx_word = '0;
    logic [15:0] sfx_dur  = '0;
    logic [3:0]  t0_os, t1_os, t2_os, t3_os;
    logic        busy;
    logic [1:0]  active_id;
    logic [3:0]  ack;
    logic        done;

    sfx_scheduler #(.NUM_REQ(4), .DUR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .note_clk  (note_clk),
        .enable    (enable),
        .flush     (flush),
        .req       (req),
        .sfx_word  (sfx_word),
        .sfx_dur   (sfx_dur),
        .t0_os     (t0_os),
        .t1_os     (t1_os),
        .t2_os     (t2_os),
        .t3_os     (t3_os),
        .busy      (busy),
        .active_id (active_id),
        .ack       (ack),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;  // 0 = ack, 1 = done
        int          id;
        logic [15:0] word;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, want);
        end
    endtask

    function automatic int tones();
        return int'({t0_os, t1_os, t2_os, t3_os});
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_fx(input int id, input logic [15:0] w, input logic [3:0] d);
        sfx_word[id*16 +: 16] = w;
        sfx_dur[id*4 +: 4]    = d;
    endtask

    task automatic expect_ack(input int id, input logic [15:0] w, input int at);
        exp_q.push_back('{0, id, w, at});
    endtask

    // One note_clk pulse (2 cycles). A final tick driven now completes one cycle later.
    task automatic pulse_note(input bit last);
        if (last) exp_q.push_back('{1, 0, 16'h0000, cyc + 1});
        note_clk = 1'b1;
        step(1);
        note_clk = 1'b0;
        step(1);
    endtask

    // Monitor: every ack/done pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset && (ack != '0 || done)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event at cycle %0d: ack=%b done=%b, required no event", cyc, ack, done);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", (ack != '0) ? 0 : 1, mon_e.kind);
                chk("event_cycle", cyc, mon_e.cyc);
                if (mon_e.kind == 0) begin
                    chk("ack_vector", int'(ack), 1 << mon_e.id);
                    chk("ack_active_id", int'(active_id), mon_e.id);
                    chk("ack_tones", tones(), int'(mon_e.word));
                    chk("ack_busy", int'(busy), 1);
                end else begin
                    chk("done_tones", tones(), 0);
                    chk("done_busy", int'(busy), 0);
                end
            end
        end
    end

    int c0;

    initial begin
        // Reset state
        step(3);
        chk("rst_tones", tones(), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_active_id", int'(active_id), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        step(2);

        // 1: single request, three-tick hold
        set_fx(2, 16'h5000, 4'd3);
        c0 = cyc;
        expect_ack(2, 16'h5000, c0 + 2);
        req = 4'b0100;
        step(2);
        chk("t1_t0_os", int'(t0_os), 5);
        pulse_note(0);
        pulse_note(0);
        pulse_note(1);
        chk("t1_after_tones", tones(), 0);
        chk("t1_after_busy", int'(busy), 0);
        req = '0;
        step(2);

        // 2: simultaneous requests, lower index first, one gap cycle between
        set_fx(1, 16'h1234, 4'd1);
        set_fx(3, 16'hABCD, 4'd2);
        c0 = cyc;
        expect_ack(1, 16'h1234, c0 + 2);
        req = 4'b1010;
        step(2);
        pulse_note(1);                    // done at c0+3
        expect_ack(3, 16'hABCD, c0 + 4);  // grant one cycle after done
        pulse_note(0);
        pulse_note(1);
        req = '0;
        step(2);

        // 3: preemption by requester 0; requester 3 is not replayed
        set_fx(3, 16'h0808, 4'd8);
        set_fx(0, 16'h7777, 4'd2);
        c0 = cyc;
        expect_ack(3, 16'h0808, c0 + 2);
        req = 4'b1000;
        step(2);
        pulse_note(0);
        c0 = cyc;
        expect_ack(0, 16'h7777, c0 + 2);
        req = 4'b1001;
        step(2);
        chk("t3_preempt_tones", tones(), 16'h7777);
        pulse_note(0);
        pulse_note(1);
        req = '0;
        step(6);
        chk("t3_no_replay_busy", int'(busy), 0);

        // 4: zero duration acts as one tick; enable=0 freezes the counter
        set_fx(0, 16'h0F00, 4'd0);
        c0 = cyc;
        expect_ack(0, 16'h0F00, c0 + 2);
        req = 4'b0001;
        step(2);
        enable = 1'b0;
        repeat (5) pulse_note(0);
        chk("t4_hold_busy", int'(busy), 1);
        chk("t4_hold_tones", tones(), 16'h0F00);
        enable = 1'b1;
        pulse_note(1);
        req = '0;
        step(2);

        // 5: flush during PLAY with requester 1 pending; rise during flush dropped
        set_fx(0, 16'h2222, 4'd4);
        set_fx(1, 16'h1111, 4'd4);
        set_fx(2, 16'h9999, 4'd1);
        c0 = cyc;
        expect_ack(0, 16'h2222, c0 + 2);
        req = 4'b0001;
        step(2);
        req = 4'b0011;
        step(1);
        flush = 1'b1;
        req   = 4'b0111;
        step(1);
        flush = 1'b0;
        chk("t5_flush_busy", int'(busy), 0);
        chk("t5_flush_tones", tones(), 0);
        step(10);
        chk("t5_idle_busy", int'(busy), 0);
        req = '0;
        step(2);

        // 6: asynchronous reset mid-PLAY; held request needs a new edge
        set_fx(2, 16'h4444, 4'd5);
        c0 = cyc;
        expect_ack(2, 16'h4444, c0 + 2);
        req = 4'b0100;
        step(3);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_tones", tones(), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_active_id", int'(active_id), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(8);
        chk("t6_held_no_grant", int'(busy), 0);
        req = '0;
        step(1);
        set_fx(2, 16'h4444, 4'd1);
        c0 = cyc;
        expect_ack(2, 16'h4444, c0 + 2);
        req = 4'b0100;
        step(2);
        pulse_note(1);
        req = '0;
        step(3);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
